// File: rtl/rvmem_pkg.sv
// Shared types and constants for the rvmem_arbiter IF/LS memory arbiter.
package rvmem_pkg;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_e;
   typedef enum logic {OWN_IF, OWN_LS} owner_e;

   localparam int STARVE_CNT_W = 4;
   localparam int LAT_CNT_W    = 2;
   localparam int STAT_W       = 16;

   function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/rvmem_arbiter_if.sv
// Bundle of fetch, load/store and memory-macro signals seen by rvmem_arbiter.
interface rvmem_arbiter_if
   import rvmem_pkg::*;
#(
   parameter int WIDTH    = 32,
   parameter int ADDRSIZE = 8
);
   logic                if_req_valid;
   logic                if_req_ready;
   logic [ADDRSIZE-1:0] if_req_addr;
   logic                if_rsp_valid;
   logic [WIDTH-1:0]    if_rsp_data;
   logic                ls_req_valid;
   logic                ls_req_ready;
   logic                ls_req_we;
   logic [ADDRSIZE-1:0] ls_req_addr;
   logic [WIDTH-1:0]    ls_req_wdata;
   logic                ls_rsp_valid;
   logic [WIDTH-1:0]    ls_rsp_data;
   logic                mem_en;
   logic                mem_we;
   logic [ADDRSIZE-1:0] mem_address;
   logic [WIDTH-1:0]    mem_dataout;
   logic [WIDTH-1:0]    mem_datain;

   // Requesters plus memory macro side.
   modport master (
      output if_req_valid, if_req_addr, ls_req_valid, ls_req_we, ls_req_addr,
             ls_req_wdata, mem_datain,
      input  if_req_ready, if_rsp_valid, if_rsp_data, ls_req_ready, ls_rsp_valid,
             ls_rsp_data, mem_en, mem_we, mem_address, mem_dataout
   );

   // Arbiter side.
   modport slave (
      input  if_req_valid, if_req_addr, ls_req_valid, ls_req_we, ls_req_addr,
             ls_req_wdata, mem_datain,
      output if_req_ready, if_rsp_valid, if_rsp_data, ls_req_ready, ls_rsp_valid,
             ls_rsp_data, mem_en, mem_we, mem_address, mem_dataout
   );

endinterface

// File: rtl/rvmem_arb_grant.sv
// Winner select between fetch and load/store with a starvation counter for fetch.
// RVMEM_ARB_STATS_EN adds the forced-win indication used by the statistics.
module rvmem_arb_grant
   import rvmem_pkg::*;
#(
   parameter int STARVE_MAX = 4
)
(
   input  logic clk,
   input  logic rst,
   input  logic idle,
   input  logic if_valid,
   input  logic ls_valid,
   output logic if_win,
   output logic ls_win
`ifdef RVMEM_ARB_STATS_EN
   ,
   output logic forced
`endif
);

   logic [STARVE_CNT_W-1:0] starve_cnt;
   logic                    starved;

   assign starved = (starve_cnt == STARVE_CNT_W'(STARVE_MAX));
   assign if_win  = idle && if_valid && (!ls_valid || starved);
   assign ls_win  = idle && ls_valid && !(if_valid && starved);

`ifdef RVMEM_ARB_STATS_EN
   assign forced = idle && if_valid && ls_valid && starved;
`endif

   // Only LS wins that actually denied a waiting fetch count toward starvation.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         starve_cnt <= '0;
      end else if (if_win) begin
         starve_cnt <= '0;
      end else if (ls_win && if_valid && !(&starve_cnt)) begin
         starve_cnt <= starve_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/rvmem_arbiter.sv
// Single-outstanding arbiter sharing one synchronous memory port between fetch and LSU.
// Optional 16-bit grant statistics ports when RVMEM_ARB_STATS_EN is defined.
//
// state | meaning
// IDLE  | arbitrate, ready to the winner only
// ISSUE | mem_en driven with the registered request
// WAIT  | count down memory read latency, capture data at zero
module rvmem_arbiter
   import rvmem_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter int ADDRSIZE   = 8,
   parameter int MEM_LAT    = 1,
   parameter int STARVE_MAX = 4
)
(
   input  logic             clk,
   input  logic             rst,
   rvmem_arbiter_if.slave   bus
`ifdef RVMEM_ARB_STATS_EN
   ,
   output logic [STAT_W-1:0] stat_if_grants,
   output logic [STAT_W-1:0] stat_ls_grants,
   output logic [STAT_W-1:0] stat_starve_forced
`endif
);

   localparam logic [1:0] S_IDLE  = 2'(IDLE);
   localparam logic [1:0] S_ISSUE = 2'(ISSUE);
   localparam logic [1:0] S_WAIT  = 2'(WAIT);

   logic [1:0]           state;
   owner_e               owner;
   logic                 req_we;
   logic [LAT_CNT_W-1:0] lat_cnt;
   logic [ADDRSIZE-1:0]  mem_address_q;
   logic [WIDTH-1:0]     mem_dataout_q;
   logic                 if_rsp_valid_q;
   logic                 ls_rsp_valid_q;
   logic [WIDTH-1:0]     if_rsp_data_q;
   logic [WIDTH-1:0]     ls_rsp_data_q;
   logic                 idle;
   logic                 if_win;
   logic                 ls_win;

   // Gate with rst so ready stays low while reset is held.
   assign idle = (state == S_IDLE) && !rst;

`ifdef RVMEM_ARB_STATS_EN
   logic forced;
`endif

   rvmem_arb_grant #(.STARVE_MAX(STARVE_MAX)) u_grant (
      .clk      (clk),
      .rst      (rst),
      .idle     (idle),
      .if_valid (bus.if_req_valid),
      .ls_valid (bus.ls_req_valid),
      .if_win   (if_win),
      .ls_win   (ls_win)
`ifdef RVMEM_ARB_STATS_EN
      ,
      .forced   (forced)
`endif
   );

   assign bus.if_req_ready = if_win;
   assign bus.ls_req_ready = ls_win;
   assign bus.mem_en       = (state == S_ISSUE);
   assign bus.mem_we       = (state == S_ISSUE) && req_we;
   assign bus.mem_address  = mem_address_q;
   assign bus.mem_dataout  = mem_dataout_q;
   assign bus.if_rsp_valid = if_rsp_valid_q;
   assign bus.if_rsp_data  = if_rsp_data_q;
   assign bus.ls_rsp_valid = ls_rsp_valid_q;
   assign bus.ls_rsp_data  = ls_rsp_data_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= S_IDLE;
         owner          <= OWN_IF;
         req_we         <= 1'b0;
         lat_cnt        <= '0;
         mem_address_q  <= '0;
         mem_dataout_q  <= '0;
         if_rsp_valid_q <= 1'b0;
         ls_rsp_valid_q <= 1'b0;
         if_rsp_data_q  <= '0;
         ls_rsp_data_q  <= '0;
      end else begin
         if_rsp_valid_q <= 1'b0;
         ls_rsp_valid_q <= 1'b0;
         case (state)
            S_IDLE: begin
               if (if_win) begin
                  owner         <= OWN_IF;
                  req_we        <= 1'b0;
                  mem_address_q <= bus.if_req_addr;
                  state         <= S_ISSUE;
               end else if (ls_win) begin
                  owner         <= OWN_LS;
                  req_we        <= bus.ls_req_we;
                  mem_address_q <= bus.ls_req_addr;
                  if (bus.ls_req_we) begin
                     mem_dataout_q <= bus.ls_req_wdata;
                  end
                  state         <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (req_we) begin
                  ls_rsp_valid_q <= 1'b1;
                  ls_rsp_data_q  <= '0;
                  state          <= S_IDLE;
               end else begin
                  lat_cnt <= LAT_CNT_W'(MEM_LAT - 1);
                  state   <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (lat_cnt == '0) begin
                  if (owner == OWN_IF) begin
                     if_rsp_valid_q <= 1'b1;
                     if_rsp_data_q  <= bus.mem_datain;
                  end else begin
                     ls_rsp_valid_q <= 1'b1;
                     ls_rsp_data_q  <= bus.mem_datain;
                  end
                  state <= S_IDLE;
               end else begin
                  lat_cnt <= lat_cnt - 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

`ifdef RVMEM_ARB_STATS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_if_grants     <= '0;
         stat_ls_grants     <= '0;
         stat_starve_forced <= '0;
      end else begin
         if (if_win) stat_if_grants <= sat_inc(stat_if_grants);
         if (ls_win) stat_ls_grants <= sat_inc(stat_ls_grants);
         if (forced) stat_starve_forced <= sat_inc(stat_starve_forced);
      end
   end
`endif

endmodule

// File: tb/tb_rvmem_arbiter.sv
// Scoreboard bench for rvmem_arbiter: one instance at MEM_LAT=1, one at MEM_LAT=3.
// Statistics checks are compiled in when RVMEM_ARB_STATS_EN is defined.
module tb_rvmem_arbiter;
   import rvmem_pkg::*;

   typedef struct {
      logic        own_ls;
      logic        we;
      logic [7:0]  addr;
      logic [31:0] wdata;
      logic [31:0] data;
      int          acc;
      int          rsp;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   int   n_tests = 0;
   int   n_fail = 0;
   int   acc3 = 0;

   exp_t sb1[$];
   exp_t sb3[$];
   int   grant_log[$];
   int   rsp3_cyc[$];

   logic [31:0] mem1 [256];
   logic [31:0] ref1 [256];
   logic [31:0] mem3 [256];
   logic [31:0] ref3 [256];
   logic [31:0] pipe1;
   logic [31:0] p3 [3];

   rvmem_arbiter_if #(.WIDTH(32), .ADDRSIZE(8)) b1 ();
   rvmem_arbiter_if #(.WIDTH(32), .ADDRSIZE(8)) b3 ();

`ifdef RVMEM_ARB_STATS_EN
   logic [STAT_W-1:0] st1_if, st1_ls, st1_f, st3_if, st3_ls, st3_f;
`endif

   rvmem_arbiter #(.WIDTH(32), .ADDRSIZE(8), .MEM_LAT(1), .STARVE_MAX(4)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (b1)
`ifdef RVMEM_ARB_STATS_EN
      ,
      .stat_if_grants     (st1_if),
      .stat_ls_grants     (st1_ls),
      .stat_starve_forced (st1_f)
`endif
   );

   rvmem_arbiter #(.WIDTH(32), .ADDRSIZE(8), .MEM_LAT(3), .STARVE_MAX(4)) u_dut3 (
      .clk (clk),
      .rst (rst),
      .bus (b3)
`ifdef RVMEM_ARB_STATS_EN
      ,
      .stat_if_grants     (st3_if),
      .stat_ls_grants     (st3_ls),
      .stat_starve_forced (st3_f)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Memory macro models: data appears MEM_LAT cycles after the mem_en cycle.
   always @(posedge clk) begin
      if (b1.mem_en && b1.mem_we) mem1[b1.mem_address] <= b1.mem_dataout;
      pipe1 <= mem1[b1.mem_address];
      if (b3.mem_en && b3.mem_we) mem3[b3.mem_address] <= b3.mem_dataout;
      p3[0] <= mem3[b3.mem_address];
      p3[1] <= p3[0];
      p3[2] <= p3[1];
   end
   assign b1.mem_datain = pipe1;
   assign b3.mem_datain = p3[2];

   always @(negedge clk) begin : mon1
      exp_t e;
      if (rst) begin
         sb1.delete();
      end else begin
         if (b1.mem_en) begin
            if (sb1.size() == 0) check("issue_unexpected", 1, 0);
            else begin
               check("issue_cycle", cyc, sb1[0].acc + 1);
               check("issue_addr", b1.mem_address, sb1[0].addr);
               check("issue_we", b1.mem_we, sb1[0].we);
               if (sb1[0].we) check("issue_wdata", b1.mem_dataout, sb1[0].wdata);
            end
         end
         if (b1.if_rsp_valid || b1.ls_rsp_valid) begin
            if (sb1.size() == 0) check("rsp_unexpected", 1, 0);
            else begin
               e = sb1.pop_front();
               check("rsp_owner", b1.ls_rsp_valid, e.own_ls);
               check("rsp_single", b1.if_rsp_valid && b1.ls_rsp_valid, 0);
               check("rsp_cycle", cyc, e.rsp);
               check("rsp_data", b1.ls_rsp_valid ? b1.ls_rsp_data : b1.if_rsp_data, e.data);
            end
         end
         if (b1.if_req_ready && b1.ls_req_ready) check("both_ready", 1, 0);
         if (b1.if_req_valid && b1.if_req_ready) begin
            e.own_ls = 1'b0; e.we = 1'b0; e.addr = b1.if_req_addr; e.wdata = '0;
            e.data = ref1[b1.if_req_addr]; e.acc = cyc; e.rsp = cyc + 3;
            sb1.push_back(e);
            grant_log.push_back(0);
         end else if (b1.ls_req_valid && b1.ls_req_ready) begin
            e.own_ls = 1'b1; e.we = b1.ls_req_we; e.addr = b1.ls_req_addr;
            e.wdata = b1.ls_req_wdata; e.acc = cyc;
            if (b1.ls_req_we) begin
               e.data = '0; e.rsp = cyc + 2;
               ref1[b1.ls_req_addr] = b1.ls_req_wdata;
            end else begin
               e.data = ref1[b1.ls_req_addr]; e.rsp = cyc + 3;
            end
            sb1.push_back(e);
            grant_log.push_back(1);
         end
      end
   end

   always @(negedge clk) begin : mon3
      exp_t e;
      if (rst) begin
         sb3.delete();
      end else begin
         if (b3.if_rsp_valid) begin
            if (sb3.size() == 0) check("l3_rsp_unexpected", 1, 0);
            else begin
               e = sb3.pop_front();
               check("l3_rsp_cycle", cyc, e.rsp);
               check("l3_rsp_data", b3.if_rsp_data, e.data);
               rsp3_cyc.push_back(cyc);
            end
         end
         if (b3.if_req_valid && b3.if_req_ready) begin
            e.own_ls = 1'b0; e.we = 1'b0; e.addr = b3.if_req_addr; e.wdata = '0;
            e.data = ref3[b3.if_req_addr]; e.acc = cyc; e.rsp = cyc + 5;
            sb3.push_back(e);
            acc3++;
         end
      end
   end

   task automatic if_read1(input logic [7:0] a);
      int n = 0;
      b1.if_req_valid = 1'b1;
      b1.if_req_addr  = a;
      @(negedge clk);
      while (!b1.if_req_ready && n < 50) begin @(negedge clk); n++; end
      if (!b1.if_req_ready) check("if_accept_timeout", 0, 1);
      @(posedge clk); #1;
      b1.if_req_valid = 1'b0;
   endtask

   task automatic ls_op1(input logic we, input logic [7:0] a, input logic [31:0] d);
      int n = 0;
      b1.ls_req_valid = 1'b1;
      b1.ls_req_we    = we;
      b1.ls_req_addr  = a;
      b1.ls_req_wdata = d;
      @(negedge clk);
      while (!b1.ls_req_ready && n < 50) begin @(negedge clk); n++; end
      if (!b1.ls_req_ready) check("ls_accept_timeout", 0, 1);
      @(posedge clk); #1;
      b1.ls_req_valid = 1'b0;
   endtask

   task automatic wait_done1();
      int n = 0;
      while (sb1.size() != 0 && n < 50) begin @(negedge clk); n++; end
      if (sb1.size() != 0) check("rsp_timeout", sb1.size(), 0);
      @(posedge clk); #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int cnt;
      for (int i = 0; i < 256; i++) begin
         mem1[i] = 32'hA000_0000 + i;
         mem3[i] = 32'h3000_0000 + i * 32'h11;
      end
      mem1[5] = 32'hDEADBEEF;
      for (int i = 0; i < 256; i++) begin
         ref1[i] = mem1[i];
         ref3[i] = mem3[i];
      end
      b1.if_req_valid = 1'b1; b1.if_req_addr = '0;
      b1.ls_req_valid = 1'b1; b1.ls_req_we = 1'b0; b1.ls_req_addr = '0; b1.ls_req_wdata = '0;
      b3.if_req_valid = 1'b0; b3.if_req_addr = '0;
      b3.ls_req_valid = 1'b0; b3.ls_req_we = 1'b0; b3.ls_req_addr = '0; b3.ls_req_wdata = '0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_if_ready", b1.if_req_ready, 0);
      check("rst_ls_ready", b1.ls_req_ready, 0);
      check("rst_if_rsp_valid", b1.if_rsp_valid, 0);
      check("rst_ls_rsp_valid", b1.ls_rsp_valid, 0);
      check("rst_if_rsp_data", b1.if_rsp_data, 0);
      check("rst_ls_rsp_data", b1.ls_rsp_data, 0);
      check("rst_mem_en", b1.mem_en, 0);
      check("rst_mem_we", b1.mem_we, 0);
      check("rst_mem_address", b1.mem_address, 0);
      check("rst_mem_dataout", b1.mem_dataout, 0);
      b1.if_req_valid = 1'b0;
      b1.ls_req_valid = 1'b0;
      @(negedge clk) rst = 1'b0;
      @(posedge clk); #1;

      // Basic fetch, top-of-range fetch, store then load-back.
      if_read1(8'h05);
      wait_done1();
      if_read1(8'hFF);
      wait_done1();
      ls_op1(1'b1, 8'h10, 32'h1234_5678);
      wait_done1();
      ls_op1(1'b0, 8'h10, 32'h0);
      wait_done1();

      // Reset during the WAIT cycle of a fetch drops it.
      if_read1(8'h07);
      @(posedge clk); #2;
      b1.ls_req_valid = 1'b1;
      rst = 1'b1;
      #1;
      check("mid_rst_if_rsp_data", b1.if_rsp_data, 0);
      check("mid_rst_ls_rsp_data", b1.ls_rsp_data, 0);
      check("mid_rst_mem_address", b1.mem_address, 0);
      check("mid_rst_mem_dataout", b1.mem_dataout, 0);
      check("mid_rst_ls_ready", b1.ls_req_ready, 0);
      check("mid_rst_mem_en", b1.mem_en, 0);
      repeat (2) @(posedge clk);
      b1.ls_req_valid = 1'b0;
      @(negedge clk) rst = 1'b0;
      cnt = 0;
      repeat (8) begin
         @(negedge clk);
         if (b1.if_rsp_valid) cnt++;
      end
      check("dropped_rsp", cnt, 0);
      @(posedge clk); #1;

      // Continuous contention from reset: LS x4 then forced IF, repeating.
      rst = 1'b1;
      @(posedge clk); #1;
      @(negedge clk) rst = 1'b0;
      @(posedge clk); #1;
      grant_log.delete();
      b1.if_req_addr = 8'h20;
      b1.ls_req_addr = 8'h30;
      b1.ls_req_we   = 1'b0;
      b1.if_req_valid = 1'b1;
      b1.ls_req_valid = 1'b1;
      n = 0;
      while (grant_log.size() < 20 && n < 500) begin @(posedge clk); n++; end
      #1;
      b1.if_req_valid = 1'b0;
      b1.ls_req_valid = 1'b0;
      check("grant_count", grant_log.size(), 20);
      for (int i = 0; i < grant_log.size(); i++)
         check($sformatf("grant_seq_%0d", i), grant_log[i], (i % 5 == 4) ? 0 : 1);
      wait_done1();
`ifdef RVMEM_ARB_STATS_EN
      check("stat_ls_grants", st1_ls, 16);
      check("stat_if_grants", st1_if, 4);
      check("stat_starve_forced", st1_f, 4);
`endif

      // MEM_LAT=3 back-to-back fetches of 0..3.
      b3.if_req_addr  = 8'h00;
      b3.if_req_valid = 1'b1;
      n = 0;
      while (acc3 < 4 && n < 200) begin
         @(posedge clk); #1;
         n++;
         b3.if_req_addr = 8'(acc3);
      end
      b3.if_req_valid = 1'b0;
      n = 0;
      while (sb3.size() != 0 && n < 50) begin @(negedge clk); n++; end
      check("l3_rsp_count", rsp3_cyc.size(), 4);
      for (int i = 1; i < rsp3_cyc.size(); i++)
         check($sformatf("l3_rsp_spacing_%0d", i), rsp3_cyc[i] - rsp3_cyc[i-1], 5);

      @(posedge clk); #1;
      check("sb1_empty", sb1.size(), 0);
      check("sb3_empty", sb3.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/rvmem_arbiter.md
Name: rvmem_arbiter

Overview:
Shares the single-port synchronous instruction/data memory between two requesters: the instruction-fetch unit (IF, read-only) and the load/store unit (LS, read/write). Sits between the RV32I core's fetch and LSU paths and the memory macro. Allows one outstanding transaction at a time. LS has fixed priority, and a starvation counter guarantees fetch progress.

Parameters:
WIDTH, 32, data bus width
ADDRSIZE, 8, word address width
MEM_LAT, 1, memory read latency in cycles (legal 1..4)
STARVE_MAX, 4, consecutive lost arbitrations after which IF is forced to win (legal 1..15)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
if_req_valid  in  1  fetch request
if_req_ready  out  1  fetch request accepted this cycle
if_req_addr  in  ADDRSIZE  fetch word address
if_rsp_valid  out  1  one-cycle pulse, fetch data valid
if_rsp_data  out  WIDTH  fetched word
ls_req_valid  in  1  load/store request
ls_req_ready  out  1  load/store request accepted
ls_req_we  in  1  1=store, 0=load
ls_req_addr  in  ADDRSIZE  word address
ls_req_wdata  in  WIDTH  store data
ls_rsp_valid  out  1  one-cycle pulse: load data valid or store done
ls_rsp_data  out  WIDTH  load data (0 for stores)
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable
mem_address  out  ADDRSIZE  memory address
mem_dataout  out  WIDTH  memory write data
mem_datain  in  WIDTH  memory read data, valid MEM_LAT cycles after the mem_en cycle

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; starve_cnt=0.
  - All outputs 0.
  - Any in-flight transaction is dropped and no response is emitted after reset deasserts.
- Handshake: a request transfers on the rising edge where valid&&ready. The requester holds valid, addr, we and wdata stable until accepted. Responses have no backpressure.
- ready is combinational. It is asserted only in IDLE, and only to the arbitration winner. The loser sees ready=0.
- Arbitration in IDLE:
  - If only one requester is valid, it wins.
  - If both are valid, LS wins unless starve_cnt==STARVE_MAX, in which case IF wins.
- starve_cnt:
  - Increments, saturating, on every acceptance where IF was valid and LS won.
  - Clears on any IF acceptance.
- FSM:
  - IDLE -> ISSUE on acceptance.
  - ISSUE: mem_en=1; mem_we/mem_address/mem_dataout are the registered request fields.
    - Store: ISSUE -> IDLE, with ls_rsp_valid=1 and ls_rsp_data=0 in the following cycle.
    - Load or fetch: ISSUE -> WAIT with lat_cnt=MEM_LAT-1.
  - WAIT: lat_cnt decrements each cycle. At lat_cnt==0, capture mem_datain into the owner's rsp_data, pulse the owner's rsp_valid next cycle, and go to IDLE.
- Read latency: acceptance edge E. mem_en is high in cycle E+1. rsp_valid is high in cycle E+2+MEM_LAT.
- A new request can be accepted in the same cycle as the previous rsp_valid. Throughput is 1 read per 2+MEM_LAT cycles and 1 store per 2 cycles.
- Outside the ISSUE cycle: mem_en=0, mem_we=0, and mem_address/mem_dataout hold their last values.
- rsp_data holds its value until the next capture for that requester.
- No address range check: addresses wrap naturally in ADDRSIZE bits.

Optional Feature:
RVMEM_ARB_STATS_EN
- Defined: adds three output ports, each 16-bit and saturating, cleared by rst:
  - stat_if_grants: IF acceptances.
  - stat_ls_grants: LS acceptances.
  - stat_starve_forced: arbitrations won by IF because starve_cnt==STARVE_MAX.
- Undefined: the ports and counters do not exist. Functional behaviour is identical.

Decomposition:
- Package rvmem_pkg:
  - state enum {IDLE, ISSUE, WAIT}.
  - owner enum {OWN_IF, OWN_LS}.
  - STARVE_CNT_W=4, LAT_CNT_W=2, STAT_W=16.
- Sub-module rvmem_arb_grant: combinational winner select plus the starve_cnt register, instantiated once.

Test Plan:
- Reset, then IF read at addr 0x05 (mem[5]=0xDEADBEEF), MEM_LAT=1 -> mem_en high in cycle E+1; if_rsp_valid in cycle E+3 with data 0xDEADBEEF.
- LS store addr 0x10, wdata 0x12345678, then LS load 0x10 -> ls_rsp_valid 2 cycles after store acceptance; load returns 0x12345678.
- IF and LS both valid continuously, STARVE_MAX=4 -> grant sequence LS,LS,LS,LS,IF repeating; no IF starvation.
- rst asserted during WAIT of a fetch -> all outputs 0 immediately; after release, no if_rsp_valid pulse for the dropped read.
- MEM_LAT=3, back-to-back IF reads of 0x00..0x03 -> one response every 5 cycles with data in address order.
- RVMEM_ARB_STATS_EN defined, starvation test run for 20 acceptances -> stat_ls_grants=16, stat_if_grants=4, stat_starve_forced=4.
